// File: rtl/rf_wb_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rf_wb_scoreboard: register busy-bit scoreboard with two-requester round-robin
// writeback arbitration. Optional macro RF_WB_BYPASS_EN. Rev 1.0
// ----------------------------------------------------------------------------
module rf_wb_scoreboard #(
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            iss_valid,
   output logic            iss_ready,
   input  logic [AW-1:0]   iss_rs1,
   input  logic [AW-1:0]   iss_rs2,
   input  logic [AW-1:0]   iss_rd,
   input  logic            iss_rd_we,
   input  logic            wb0_valid,
   input  logic [AW-1:0]   wb0_rd,
   input  logic [DW-1:0]   wb0_data,
   output logic            wb0_ready,
   input  logic            wb1_valid,
   input  logic [AW-1:0]   wb1_rd,
   input  logic [DW-1:0]   wb1_data,
   output logic            wb1_ready,
   output logic            rf_we,
   output logic [AW-1:0]   rf_waddr,
   output logic [DW-1:0]   rf_wdata,
   output logic [NREG-1:0] busy_vec,
   output logic            err_stray
);

   logic [NREG-1:0] r_busy;
   logic            r_rr_ptr;
   logic            r_err_stray;

   logic            w_gnt0;
   logic            w_gnt1;
   logic            w_gnt_any;
   logic [AW-1:0]   w_gnt_rd;
   logic [DW-1:0]   w_gnt_data;
   logic            w_clr_en;
   logic [NREG-1:0] w_clr_mask;
   logic [NREG-1:0] w_set_mask;
   logic [NREG-1:0] w_busy_eff;
   logic            w_ready;
   logic            w_fire;

   // Both valid: rr_ptr picks; a lone requester always wins.
   always_comb begin
      w_gnt0     = rst & wb0_valid & (~wb1_valid | ~r_rr_ptr);
      w_gnt1     = rst & wb1_valid & (~wb0_valid |  r_rr_ptr);
      w_gnt_any  = w_gnt0 | w_gnt1;
      w_gnt_rd   = w_gnt1 ? wb1_rd   : wb0_rd;
      w_gnt_data = w_gnt1 ? wb1_data : wb0_data;
      w_clr_en   = w_gnt_any & (w_gnt_rd != '0);
   end

   always_comb begin
      w_clr_mask = '0;
      for (int i = 0; i < NREG; i++) begin
         w_clr_mask[i] = w_clr_en && (w_gnt_rd == AW'(i));
      end
   end

`ifdef RF_WB_BYPASS_EN
   assign w_busy_eff = r_busy & ~w_clr_mask & ~NREG'(1);
`else
   assign w_busy_eff = r_busy & ~NREG'(1);
`endif

   always_comb begin
      w_ready = rst & ~w_busy_eff[iss_rs1] & ~w_busy_eff[iss_rs2]
              & ~(iss_rd_we & w_busy_eff[iss_rd]);
      w_fire  = iss_valid & w_ready;
   end

   always_comb begin
      w_set_mask = '0;
      for (int i = 1; i < NREG; i++) begin
         w_set_mask[i] = w_fire && iss_rd_we && (iss_rd == AW'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_busy      <= '0;
         r_rr_ptr    <= 1'b0;
         r_err_stray <= 1'b0;
      end else begin
         // Set applied after clear so a same-edge re-issue keeps the bit.
         r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~NREG'(1);
         if (w_clr_en && !r_busy[w_gnt_rd]) begin
            r_err_stray <= 1'b1;
         end
         if (w_gnt0 && wb1_valid) begin
            r_rr_ptr <= 1'b1;
         end else if (w_gnt1 && wb0_valid) begin
            r_rr_ptr <= 1'b0;
         end
      end
   end

   assign iss_ready = w_ready;
   assign wb0_ready = w_gnt0;
   assign wb1_ready = w_gnt1;
   assign rf_we     = w_clr_en;
   assign rf_waddr  = w_gnt_any ? w_gnt_rd   : '0;
   assign rf_wdata  = w_gnt_any ? w_gnt_data : '0;
   assign busy_vec  = r_busy;
   assign err_stray = r_err_stray;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_scoreboard.sv
`default_nettype none
// Bench for rf_wb_scoreboard: directed vector table plus randomized run against a reference model.
module tb_rf_wb_scoreboard;

`ifdef RF_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid, iss_ready, iss_rd_we;
   logic [4:0]  iss_rs1, iss_rs2, iss_rd;
   logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
   logic [4:0]  wb0_rd, wb1_rd;
   logic [31:0] wb0_data, wb1_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] busy_vec;
   logic        err_stray;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   rf_wb_scoreboard dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_rd_we(iss_rd_we),
      .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
      .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .busy_vec(busy_vec), .err_stray(err_stray)
   );

   typedef struct {
      logic        rst, iv;
      logic [4:0]  rs1, rs2, rd;
      logic        we, v0;
      logic [4:0]  rd0;
      logic [31:0] d0;
      logic        v1;
      logic [4:0]  rd1;
      logic [31:0] d1;
      logic        e_ird, e_r0, e_r1, e_we;
      logic [4:0]  e_addr;
      logic [31:0] e_data, e_busy;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, iv, input logic [4:0] rs1, rs2, rd, input logic we,
                      input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                      input logic ird, r0, r1, ewe, input logic [4:0] addr,
                      input logic [31:0] data, busy, input logic err);
      vec_t v;
      v.rst = r; v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.we = we;
      v.v0 = v0; v.rd0 = rd0; v.d0 = d0; v.v1 = v1; v.rd1 = rd1; v.d1 = d1;
      v.e_ird = ird; v.e_r0 = r0; v.e_r1 = r1; v.e_we = ewe;
      v.e_addr = addr; v.e_data = data; v.e_busy = busy; v.e_err = err;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, iv, input logic [4:0] rs1, rs2, rd, input logic we,
                        input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] rd1, input logic [31:0] d1);
      rst = r; iss_valid = iv; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_rd_we = we;
      wb0_valid = v0; wb0_rd = rd0; wb0_data = d0;
      wb1_valid = v1; wb1_rd = rd1; wb1_data = d1;
   endtask

   task automatic check_all(input string tag, input logic ird, r0, r1, ewe,
                            input logic [4:0] addr, input logic [31:0] data, busy,
                            input logic err);
      chk({tag, " iss_ready"}, 64'(iss_ready), 64'(ird));
      chk({tag, " wb0_ready"}, 64'(wb0_ready), 64'(r0));
      chk({tag, " wb1_ready"}, 64'(wb1_ready), 64'(r1));
      chk({tag, " rf_we"},     64'(rf_we),     64'(ewe));
      chk({tag, " rf_waddr"},  64'(rf_waddr),  64'(addr));
      chk({tag, " rf_wdata"},  64'(rf_wdata),  64'(data));
      chk({tag, " busy_vec"},  64'(busy_vec),  64'(busy));
      chk({tag, " err_stray"}, 64'(err_stray), 64'(err));
   endtask

   // Reference model state: set of outstanding destinations, who goes first on a tie, sticky error.
   bit          pend[32];
   bit          wb1_first;
   bit          stray_seen;

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);

      // Reset hold with wb0 pending, then release
      for (int i = 0; i < 3; i++)
         add(0,0,0,0,0,0, 1,0,5, 0,0,0,        0,0,0,0,0,0, 0,0);
      add(1,0,0,0,0,0, 1,0,5, 0,0,0,           1,1,0,0,0,5, 0,0);
      // RAW on x5
      add(1,1,0,0,5,1, 0,0,0, 0,0,0,           1,0,0,0,0,0, 0,0);
      add(1,1,5,0,6,1, 0,0,0, 0,0,0,           0,0,0,0,0,0, 32'h20,0);
      add(1,1,5,0,6,1, 1,5,32'h20, 0,0,0,      BYP,1,0,1,5,32'h20, 32'h20,0);
      add(1,1,5,0,6,1, 0,0,0, 0,0,0,           !BYP,0,0,0,0,0, BYP ? 32'h40 : 32'h0,0);
      add(1,0,0,0,0,0, 0,0,0, 1,6,32'h66,      1,0,1,1,6,32'h66, 32'h40,0);
      // Arbitration x1 / x31
      add(1,1,0,0,1,1, 0,0,0, 0,0,0,           1,0,0,0,0,0, 0,0);
      add(1,1,0,0,31,1, 0,0,0, 0,0,0,          1,0,0,0,0,0, 32'h2,0);
      add(1,0,0,0,0,0, 1,1,32, 1,31,21,        1,1,0,1,1,32, 32'h8000_0002,0);
      add(1,0,0,0,0,0, 0,0,0, 1,31,21,         1,0,1,1,31,21, 32'h8000_0000,0);
      add(1,1,0,0,1,1, 0,0,0, 0,0,0,           1,0,0,0,0,0, 0,0);
      add(1,1,0,0,31,1, 0,0,0, 0,0,0,          1,0,0,0,0,0, 32'h2,0);
      add(1,0,0,0,0,0, 1,1,32, 1,31,21,        1,0,1,1,31,21, 32'h8000_0002,0);
      add(1,0,0,0,0,0, 1,1,32, 0,0,0,          1,1,0,1,1,32, 32'h2,0);
      // x0 destination
      add(1,1,0,0,0,1, 0,0,0, 0,0,0,           1,0,0,0,0,0, 0,0);
      add(1,0,0,0,0,0, 0,0,0, 1,0,128,         1,0,1,0,0,128, 0,0);
      // WAW on x7, then stray write to x9
      add(1,1,0,0,7,1, 0,0,0, 0,0,0,           1,0,0,0,0,0, 0,0);
      add(1,1,0,0,7,1, 0,0,0, 0,0,0,           0,0,0,0,0,0, 32'h80,0);
      add(1,1,0,0,7,1, 1,7,32'h77, 0,0,0,      BYP,1,0,1,7,32'h77, 32'h80,0);
      add(1,1,0,0,7,1, 0,0,0, 0,0,0,           !BYP,0,0,0,0,0, BYP ? 32'h80 : 32'h0,0);
      add(1,0,0,0,0,0, 1,7,1, 0,0,0,           1,1,0,1,7,1, 32'h80,0);
      add(1,0,0,0,0,0, 1,9,32'h99, 0,0,0,      1,1,0,1,9,32'h99, 0,0);
      add(1,0,0,0,0,0, 0,0,0, 0,0,0,           1,0,0,0,0,0, 0,1);
      add(1,0,0,0,0,0, 0,0,0, 0,0,0,           1,0,0,0,0,0, 0,1);
      add(0,0,0,0,0,0, 0,0,0, 0,0,0,           0,0,0,0,0,0, 0,1);
      add(1,0,0,0,0,0, 0,0,0, 0,0,0,           1,0,0,0,0,0, 0,0);

      for (int k = 0; k < tbl.size(); k++) begin
         @(negedge clk);
         drive(tbl[k].rst, tbl[k].iv, tbl[k].rs1, tbl[k].rs2, tbl[k].rd, tbl[k].we,
               tbl[k].v0, tbl[k].rd0, tbl[k].d0, tbl[k].v1, tbl[k].rd1, tbl[k].d1);
         #1;
         check_all($sformatf("vec%0d", k), tbl[k].e_ird, tbl[k].e_r0, tbl[k].e_r1,
                   tbl[k].e_we, tbl[k].e_addr, tbl[k].e_data, tbl[k].e_busy, tbl[k].e_err);
      end

      // Randomized run: registers drawn from 0..7 to force frequent hazards.
      // The last table row leaves the DUT freshly reset.
      foreach (pend[i]) pend[i] = 1'b0;
      wb1_first  = 1'b0;
      stray_seen = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         logic        r, iv, we, v0, v1, take0, take1, has_w, ready, fire;
         logic [4:0]  rs1, rs2, rd, rd0, rd1, wrd;
         logic [31:0] d0, d1, wdata, busy;
         bit          view[32];
         @(negedge clk);
         r   = ($urandom_range(0, 99) >= 3);
         iv  = $urandom_range(0, 1) == 1;
         we  = $urandom_range(0, 3) != 0;
         rs1 = 5'($urandom_range(0, 7));
         rs2 = 5'($urandom_range(0, 7));
         rd  = 5'($urandom_range(0, 7));
         v0  = $urandom_range(0, 2) == 0;
         v1  = $urandom_range(0, 2) == 0;
         rd0 = 5'($urandom_range(0, 7));
         rd1 = 5'($urandom_range(0, 7));
         d0  = $urandom;
         d1  = $urandom;
         drive(r, iv, rs1, rs2, rd, we, v0, rd0, d0, v1, rd1, d1);
         #1;
         busy = '0;
         for (int i = 0; i < 32; i++) busy[i] = pend[i];
         if (!r) begin
            check_all($sformatf("rnd%0d", n), 0, 0, 0, 0, 0, 0, busy, stray_seen);
            foreach (pend[i]) pend[i] = 1'b0;
            wb1_first  = 1'b0;
            stray_seen = 1'b0;
         end else begin
            take0 = v0 && !(v1 && wb1_first);
            take1 = v1 && !take0;
            has_w = take0 || take1;
            wrd   = take1 ? rd1 : (take0 ? rd0 : 5'd0);
            wdata = take1 ? d1  : (take0 ? d0  : 32'd0);
            foreach (view[i]) view[i] = pend[i] && i != 0;
            if (BYP && has_w && wrd != 0) view[wrd] = 1'b0;
            ready = !view[rs1] && !view[rs2] && !(we && view[rd]);
            fire  = iv && ready;
            check_all($sformatf("rnd%0d", n), ready, take0, take1, has_w && wrd != 0,
                      wrd, wdata, busy, stray_seen);
            if (has_w && wrd != 0) begin
               if (!pend[wrd]) stray_seen = 1'b1;
               pend[wrd] = 1'b0;
            end
            if (fire && we && rd != 0) pend[rd] = 1'b1;
            if (v0 && v1) wb1_first = take0;
         end
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
